// File: rtl/seven_segment_capture.sv
// Passive observer of a multiplexed 8-digit seven-segment display: debounces each
// digit dwell, decodes the glyph and rebuilds the digit word, dot mask and lit mask.
module seven_segment_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pos,
  input  logic [7:0]  segments,
  output logic [31:0] digit,
  output logic [7:0]  dot,
  output logic [7:0]  valid,
  output logic [7:0]  lit,
  output logic        frame_done,
  output logic        scan_error
);
  localparam logic [0:0]  ST_EMPTY  = 1'b0;
  localparam logic [0:0]  ST_TRACK  = 1'b1;
  localparam logic [15:0] CAP_COUNT = 16'(STABLE_CYCLES - 1);

  logic [7:0]  pos_q, pos_d, seg_q, seg_d;
  logic [7:0]  pos_prev_q, pos_prev_d, seg_prev_q, seg_prev_d;
  logic [15:0] cnt_q, cnt_d;
  logic        captured_q, captured_d;
  logic [0:0]  state_q, state_d;
  logic [2:0]  last_q, last_d;
  logic [7:0]  acc_q, acc_d;
  logic [31:0] digit_q, digit_d;
  logic [7:0]  dot_q, dot_d, valid_q, valid_d, lit_q, lit_d;
  logic        frame_done_q, frame_done_d, scan_error_q, scan_error_d;

  logic       same, one_hot, multi_hot, capture, known, blank;
  logic [2:0] idx;
  logic [3:0] glyph_val;
  logic [7:0] contrib;

  always_comb begin
    known     = 1'b1;
    glyph_val = 4'h0;
    case (seg_q[6:0])
      7'h3F: glyph_val = 4'h0;
      7'h06: glyph_val = 4'h1;
      7'h5B: glyph_val = 4'h2;
      7'h4F: glyph_val = 4'h3;
      7'h66: glyph_val = 4'h4;
      7'h6D: glyph_val = 4'h5;
      7'h7D: glyph_val = 4'h6;
      7'h07: glyph_val = 4'h7;
      7'h7F: glyph_val = 4'h8;
      7'h6F: glyph_val = 4'h9;
      7'h77: glyph_val = 4'hA;
      7'h7C: glyph_val = 4'hB;
      7'h39: glyph_val = 4'hC;
      7'h5E: glyph_val = 4'hD;
      7'h79: glyph_val = 4'hE;
      7'h71: glyph_val = 4'hF;
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pos_q[i]) idx = 3'(i);
    end
  end

  always_comb begin
    pos_d      = ACTIVE_LOW ? ~pos : pos;
    seg_d      = ACTIVE_LOW ? ~segments : segments;
    pos_prev_d = pos_q;
    seg_prev_d = seg_q;

    same      = (pos_q == pos_prev_q) && (seg_q == seg_prev_q);
    one_hot   = (pos_q != 8'h00) && ((pos_q & (pos_q - 8'h01)) == 8'h00);
    multi_hot = (pos_q != 8'h00) && !one_hot;
    blank     = (seg_q[6:0] == 7'h00);
    contrib   = blank ? 8'h00 : (8'h01 << idx);

    // Blank gaps and multi-hot patterns hold the counter at zero.
    cnt_d = 16'h0;
    if (same && one_hot) cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'h1;
    capture    = same && one_hot && !captured_q && (cnt_d == CAP_COUNT);
    captured_d = (same && captured_q) || capture;

    state_d      = state_q;
    last_d       = last_q;
    acc_d        = acc_q;
    digit_d      = digit_q;
    dot_d        = dot_q;
    valid_d      = valid_q;
    lit_d        = lit_q;
    frame_done_d = 1'b0;
    scan_error_d = multi_hot && (pos_q != pos_prev_q);

    if (capture) begin
      dot_d[idx] = seg_q[7];
      if (known) begin
        digit_d[{idx, 2'b00} +: 4] = glyph_val;
        valid_d[idx]               = 1'b1;
      end else if (!blank) begin
        valid_d[idx] = 1'b0;
        scan_error_d = 1'b1;
      end
      // An index at or below the previous one means the scan has wrapped.
      if (state_q == ST_EMPTY) begin
        state_d = ST_TRACK;
        last_d  = idx;
        acc_d   = acc_q | contrib;
      end else if (idx <= last_q) begin
        frame_done_d = 1'b1;
        lit_d        = acc_q;
        acc_d        = contrib;
        last_d       = idx;
      end else begin
        last_d = idx;
        acc_d  = acc_q | contrib;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q        <= 8'h00;
      seg_q        <= 8'h00;
      pos_prev_q   <= 8'h00;
      seg_prev_q   <= 8'h00;
      cnt_q        <= 16'h0;
      captured_q   <= 1'b0;
      state_q      <= ST_EMPTY;
      last_q       <= 3'd0;
      acc_q        <= 8'h00;
      digit_q      <= 32'h0;
      dot_q        <= 8'h00;
      valid_q      <= 8'h00;
      lit_q        <= 8'h00;
      frame_done_q <= 1'b0;
      scan_error_q <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      seg_q        <= seg_d;
      pos_prev_q   <= pos_prev_d;
      seg_prev_q   <= seg_prev_d;
      cnt_q        <= cnt_d;
      captured_q   <= captured_d;
      state_q      <= state_d;
      last_q       <= last_d;
      acc_q        <= acc_d;
      digit_q      <= digit_d;
      dot_q        <= dot_d;
      valid_q      <= valid_d;
      lit_q        <= lit_d;
      frame_done_q <= frame_done_d;
      scan_error_q <= scan_error_d;
    end
  end

  assign digit      = digit_q;
  assign dot        = dot_q;
  assign valid      = valid_q;
  assign lit        = lit_q;
  assign frame_done = frame_done_q;
  assign scan_error = scan_error_q;
endmodule
